// File: rtl/golden_nonce_check_pkg.sv
// Shared miner definitions: FSM encoding, default digest geometry and the zero-count width.
package golden_nonce_check_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 8;
  localparam int ZCNT_W        = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FOUND = 2'd2
  } state_t;

endpackage

// File: rtl/golden_nonce_check_clz.sv
// Combinational leading-zero count of one hash word; an all-zero word counts WORD_W.
module clz_word #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  count
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    count = CNT_W'(WORD_W);
    for (int i = 0; i < WORD_W; i++) begin
      if (word[i]) count = CNT_W'(WORD_W - 1 - i);
    end
  end

endmodule

// File: rtl/golden_nonce_check.sv
// Captures a digest, counts its leading zero bits one word per cycle over a fixed
// NUM_WORDS-cycle scan, and holds the nonce when the count meets the captured target.
module golden_nonce_check
  import golden_nonce_check_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hash_valid,
  output logic              hash_ready,
  input  logic [WORD_W-1:0] hash_nonce,
  input  logic [WORD_W-1:0] h1,
  input  logic [WORD_W-1:0] h2,
  input  logic [WORD_W-1:0] h3,
  input  logic [WORD_W-1:0] h4,
  input  logic [WORD_W-1:0] h5,
  input  logic [WORD_W-1:0] h6,
  input  logic [WORD_W-1:0] h7,
  input  logic [WORD_W-1:0] h8,
  input  logic [7:0]        target_zeros,
  output logic              found,
  output logic [WORD_W-1:0] golden_nonce,
  output logic [WORD_W-1:0] golden_top,
  input  logic              result_ack,
  output logic [31:0]       hashes_done,
  output logic              drop_err
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LZ_W  = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  in_words [8];
  logic [WORD_W-1:0]  words_q  [NUM_WORDS];
  logic [WORD_W-1:0]  nonce_q;
  logic [7:0]         target_q;
  logic [IDX_W-1:0]   idx_q;
  logic               seen_nz_q;
  logic [ZCNT_W-1:0]  zcnt_q, zcnt_d;
  logic [LZ_W-1:0]    word_lz;
  logic [WORD_W-1:0]  cur_word;
  logic               accept, last_word, pass;

  assign in_words = '{h1, h2, h3, h4, h5, h6, h7, h8};
  assign cur_word = words_q[idx_q];

  clz_word #(
    .WORD_W (WORD_W),
    .CNT_W  (LZ_W)
  ) u_clz (
    .word  (cur_word),
    .count (word_lz)
  );

  // Once a nonzero word has been seen, later words contribute nothing.
  assign zcnt_d    = seen_nz_q ? zcnt_q : zcnt_q + ZCNT_W'(word_lz);
  assign pass      = zcnt_d >= ZCNT_W'(target_q);
  assign last_word = (idx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    hash_ready = 1'b0;
    found      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        hash_ready = 1'b1;
        if (hash_valid) begin
          accept  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last_word) state_d = pass ? FOUND : IDLE;
      end
      FOUND: begin
        found = 1'b1;
        if (result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
      nonce_q      <= '0;
      target_q     <= '0;
      idx_q        <= '0;
      seen_nz_q    <= 1'b0;
      zcnt_q       <= '0;
      golden_nonce <= '0;
      golden_top   <= '0;
      hashes_done  <= '0;
      drop_err     <= 1'b0;
    end else begin
      if (hash_valid && !hash_ready) drop_err <= 1'b1;
      if (accept) begin
        for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= in_words[i];
        nonce_q   <= hash_nonce;
        target_q  <= target_zeros;
        idx_q     <= '0;
        seen_nz_q <= 1'b0;
        zcnt_q    <= '0;
      end else if (state_q == SCAN) begin
        zcnt_q <= zcnt_d;
        idx_q  <= idx_q + IDX_W'(1);
        if (cur_word != '0) seen_nz_q <= 1'b1;
        if (last_word) begin
          hashes_done <= hashes_done + 32'd1;
          if (pass) begin
            golden_nonce <= nonce_q;
            golden_top   <= words_q[0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_golden_nonce_check.sv
// Directed and randomized digests checked against a 256-bit leading-zero reference model.
module tb_golden_nonce_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hash_valid;
  logic        hash_ready;
  logic [31:0] hash_nonce;
  logic [31:0] h [8];
  logic [7:0]  target_zeros;
  logic        found;
  logic [31:0] golden_nonce;
  logic [31:0] golden_top;
  logic        result_ack;
  logic [31:0] hashes_done;
  logic        drop_err;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_done, exp_nonce, exp_top;

  always #5 clk = ~clk;

  golden_nonce_check dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hash_valid   (hash_valid),
    .hash_ready   (hash_ready),
    .hash_nonce   (hash_nonce),
    .h1           (h[0]),
    .h2           (h[1]),
    .h3           (h[2]),
    .h4           (h[3]),
    .h5           (h[4]),
    .h6           (h[5]),
    .h7           (h[6]),
    .h8           (h[7]),
    .target_zeros (target_zeros),
    .found        (found),
    .golden_nonce (golden_nonce),
    .golden_top   (golden_top),
    .result_ack   (result_ack),
    .hashes_done  (hashes_done),
    .drop_err     (drop_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lz(input logic [255:0] d);
    for (int i = 255; i >= 0; i--) if (d[i]) return 255 - i;
    return 256;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".golden_nonce"}, 64'(golden_nonce), 64'(exp_nonce));
    check({tag, ".golden_top"},   64'(golden_top),   64'(exp_top));
    check({tag, ".hashes_done"},  64'(hashes_done),  64'(exp_done));
  endtask

  // Offers one digest at a negedge and follows it through the 9-edge latency.
  task automatic run_digest(input string tag, input logic [31:0] nonce,
                            input logic [255:0] dig, input logic [7:0] tz, input bit ack);
    bit pass;
    hash_nonce   = nonce;
    target_zeros = tz;
    for (int w = 0; w < 8; w++) h[w] = dig[255-32*w -: 32];
    hash_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hash_valid   = 1'b0;
    target_zeros = ~tz;
    for (int w = 0; w < 8; w++) h[w] = $urandom;
    check({tag, ".ready_scan"}, 64'(hash_ready), 64'd0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check({tag, ".found_early"}, 64'(found), 64'd0);
    @(posedge clk);
    @(negedge clk);
    pass = ref_lz(dig) >= int'(tz);
    exp_done = exp_done + 32'd1;
    if (pass) begin
      exp_nonce = nonce;
      exp_top   = dig[255:224];
    end
    check({tag, ".found"}, 64'(found), 64'(pass));
    check({tag, ".ready"}, 64'(hash_ready), 64'(!pass));
    check_outputs(tag);
    if (pass && ack) begin
      result_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ack = 1'b0;
      check({tag, ".ack_found"}, 64'(found), 64'd0);
      check({tag, ".ack_ready"}, 64'(hash_ready), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] dig;
    logic [31:0]  word;
    logic [7:0]   tz;

    rst_n = 1'b0; hash_valid = 1'b0; hash_nonce = '0; target_zeros = '0; result_ack = 1'b0;
    for (int w = 0; w < 8; w++) h[w] = '0;
    exp_done = '0; exp_nonce = '0; exp_top = '0;
    #12;
    check("rst.ready", 64'(hash_ready), 64'd1);
    check("rst.found", 64'(found), 64'd0);
    check("rst.drop",  64'(drop_err), 64'd0);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst.ready", 64'(hash_ready), 64'd1);

    // result_ack while idle must do nothing
    result_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ack = 1'b0;
    check("idle_ack.ready", 64'(hash_ready), 64'd1);

    dig = {32'h00000FFF, 224'($urandom) | {192'd0, 32'hDEAD_BEEF}};
    run_digest("h1_fff_t20", 32'h1234, dig, 8'd20, 1'b1);
    run_digest("h1_ffff_t20", 32'h5555, {32'h0000FFFF, {7{32'hFFFF_FFFF}}}, 8'd20, 1'b1);
    dig = {32'h0, 32'h0FFFFFFF, {6{32'h8000_0001}}};
    run_digest("two_word_t36", 32'hA1, dig, 8'd36, 1'b1);
    run_digest("two_word_t37", 32'hA2, dig, 8'd37, 1'b1);
    run_digest("tz_zero", 32'hB0, {8{32'hFFFF_FFFF}}, 8'd0, 1'b1);
    run_digest("last_word", 32'hC0, {224'd0, 32'h0000_0001}, 8'd255, 1'b1);

    run_digest("all_zero_t255", 32'hCAFE, 256'd0, 8'd255, 1'b0);
    check("drop.before", 64'(drop_err), 64'd0);
    hash_valid = 1'b1;
    hash_nonce = 32'h9999;
    @(posedge clk);
    @(negedge clk);
    hash_valid = 1'b0;
    check("drop.flag",  64'(drop_err), 64'd1);
    check("drop.found", 64'(found), 64'd1);
    check_outputs("drop");
    result_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ack = 1'b0;
    check("drop_ack.ready", 64'(hash_ready), 64'd1);
    check("drop.sticky", 64'(drop_err), 64'd1);

    for (int n = 0; n < 24; n++) begin
      for (int w = 0; w < 8; w++) begin
        word = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
        dig[255-32*w -: 32] = word;
      end
      tz = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
      run_digest($sformatf("rand%0d", n), $urandom, dig, tz, 1'b1);
    end

    // Reset during the fourth scan cycle abandons the comparison.
    hash_nonce = 32'h7777; target_zeros = 8'd0; hash_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hash_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_done = '0; exp_nonce = '0; exp_top = '0;
    check("mid_rst.found", 64'(found), 64'd0);
    check("mid_rst.drop",  64'(drop_err), 64'd0);
    check_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_rst_rel.ready", 64'(hash_ready), 64'd1);
    check("mid_rst_rel.found", 64'(found), 64'd0);
    check_outputs("mid_rst_rel");

    force dut.hashes_done = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.hashes_done;
    exp_done = 32'hFFFF_FFFF;
    run_digest("wrap", 32'hE0, {32'h0000_00FF, {7{32'h1}}}, 8'd10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
